rc4_prga_decrypt: RTL
=====================

RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

Interface
REQ-001 Parameter MSG_LEN, default 32, ciphertext/plaintext length in bytes (legal 2..256).
REQ-002 Parameter MSG_AW, default $clog2(MSG_LEN), width of C/D address ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level request to run; sampled in IDLE only.
REQ-006 q_S  input  8  S RAM read data; address_S/data_S/wren_S outputs 8/8/1 S RAM port.
REQ-007 q_C  input  8  ciphertext ROM read data; address_C output MSG_AW.
REQ-008 data_D/address_D/wren_D  output  8/MSG_AW/1  plaintext RAM write port.
REQ-009 done  output  1  run finished (success or fail); valid  output  1  plaintext accepted.

Function
REQ-010 All memories: synchronous read, data valid on q one full cycle after the registered address changes; writes take effect on the edge where wren is high.
REQ-011 States: IDLE, RD_I, WT_I, CALC_J, RD_J, WT_J, SET_I, WR_I, SET_J, WR_J, RD_F, WT_F, CALC_D, WR_D, NEXT, DONE, FAIL.
REQ-012 IDLE: start=1 -> RD_I with i<=1, j<=0, k<=0; else stay.
REQ-013 RD_I: address_S<=i. WT_I -> CALC_J. CALC_J: si<=q_S, j<=j+q_S (mod 256).
REQ-014 RD_J: address_S<=j. WT_J -> SET_I. SET_I: sj<=q_S, address_S<=i, data_S<=q_S.
REQ-015 WR_I: wren_S=1. SET_J: address_S<=j, data_S<=si. WR_J: wren_S=1, f<=si+sj (mod 256).
REQ-016 RD_F: address_S<=f, address_C<=k. WT_F -> CALC_D. CALC_D: data_D<=q_S^q_C, address_D<=k.
REQ-017 WR_D: wren_D=1 (subject to REQ-027). NEXT: k==MSG_LEN-1 -> DONE; else k<=k+1, i<=i+1 (mod 256), -> RD_I.
REQ-018 Every listed state not given a transition advances to the next state in REQ-011 order, one cycle each; 14 cycles per byte.
REQ-019 done asserted first on the edge 1+14*MSG_LEN after the edge that sampled start.
REQ-020 wren_S high only in WR_I/WR_J; wren_D high only in WR_D; never both.
REQ-021 DONE/FAIL: done=1; hold while start=1; start=0 -> IDLE (done drops), enabling a new run with a freshly loaded S.
REQ-022 i==j case: both swap writes target same address; final S[i] equals original value (no corruption).
REQ-023 i and j wrap 255->0; k never exceeds MSG_LEN-1; when MSG_LEN=256 address_C/address_D wrap not reached.
REQ-024 start changes outside IDLE/DONE/FAIL are ignored.

Reset
REQ-025 rst=1 at any time, including mid-swap: state<=IDLE; i,j,k,f,si,sj,address_S,address_C,address_D,data_S,data_D<=0; done=0, valid=0, wren_S=0, wren_D=0 immediately (asynchronous).
REQ-026 After rst deasserts, block waits in IDLE for start; no partial run resumes.

Configuration
REQ-027 Macro RC4_VALID_CHECK_EN defined: in CALC_D the plaintext byte is checked; if not in 0x61..0x7A and not 0x20, next state FAIL (WR_D skipped, no wren_D for that byte); valid=1 only in DONE, 0 in FAIL.
REQ-028 Macro undefined: no check, FAIL unreachable, valid=1 whenever done=1.

Verification
REQ-029 MSG_LEN=4, S identity (S[x]=x), C all 0x00, macro undefined -> D = {0x02,0x05,...} (D[0]=0x02, D[1]=0x05), done at edge 57 after start, valid=1.
REQ-030 Same S, C[0]=0x63, C[1]=0x60, macro defined -> D[0]=0x61, D[1]=0x65 written; after byte 0 ok, run continues.
REQ-031 Same S, C[0]=0x00, macro defined -> FAIL after byte 0, done=1, valid=0, wren_D never high.
REQ-032 rst pulsed during WR_I of byte 2 -> all outputs 0 within same cycle, state IDLE, no further writes; rerun after reload gives REQ-029 result.
REQ-033 After DONE hold start=1 for 10 cycles -> done stays 1, no memory writes; drop start -> IDLE, done=0; reassert -> second run completes.
REQ-034 MSG_LEN=256 run -> k reaches 255, i wraps to 0 at last byte, 256 wren_D pulses, done at edge 3585.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator (PRGA) fused with a ciphertext XOR decryptor.
// Walks a pre-scheduled S box in an external synchronous RAM, swaps S[i]/S[j]
// for every byte, reads the keystream byte and the ciphertext byte, and writes
// the plaintext byte into an external result RAM.
// Optional build macro: RC4_VALID_CHECK_EN -- when defined, every plaintext
// byte must be a lowercase letter or a space, otherwise the run ends in FAIL.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        q_S,
  output logic [7:0]        address_S,
  output logic [7:0]        data_S,
  output logic              wren_S,
  input  logic [7:0]        q_C,
  output logic [MSG_AW-1:0] address_C,
  output logic [7:0]        data_D,
  output logic [MSG_AW-1:0] address_D,
  output logic              wren_D,
  output logic              done,
  output logic              valid
);

  typedef enum logic [4:0] {
    IDLE, RD_I, WT_I, CALC_J, RD_J, WT_J, SET_I, WR_I, SET_J, WR_J,
    RD_F, WT_F, CALC_D, WR_D, NEXT, DONE, FAIL
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t            state, state_next;
  logic [7:0]        i, j, f, si, sj;
  logic [MSG_AW-1:0] k;
  logic [7:0]        plain;
  logic              plain_ok;
  logic              done_next, valid_next;

  // Plaintext byte is available combinationally while both reads are valid.
  assign plain = q_S ^ q_C;

`ifdef RC4_VALID_CHECK_EN
  // Accept only 'a'..'z' or a space.
  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);
`else
  assign plain_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the single-cycle write strobes.
  always_comb begin
    state_next = state;
    wren_S     = 1'b0;
    wren_D     = 1'b0;
    unique case (state)
      IDLE:    if (start) state_next = RD_I;
      RD_I:    state_next = WT_I;
      WT_I:    state_next = CALC_J;
      CALC_J:  state_next = RD_J;
      RD_J:    state_next = WT_J;
      WT_J:    state_next = SET_I;
      SET_I:   state_next = WR_I;
      WR_I: begin
        wren_S     = 1'b1;
        state_next = SET_J;
      end
      SET_J:   state_next = WR_J;
      WR_J: begin
        wren_S     = 1'b1;
        state_next = RD_F;
      end
      RD_F:    state_next = WT_F;
      WT_F:    state_next = CALC_D;
      CALC_D:  state_next = plain_ok ? WR_D : FAIL;
      WR_D: begin
        wren_D     = 1'b1;
        state_next = NEXT;
      end
      NEXT:    state_next = (k == K_LAST) ? DONE : RD_I;
      DONE:    if (!start) state_next = IDLE;
      FAIL:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done/valid are registered; they stay up while the requester keeps start
  // high and fall on the same edge that returns the block to IDLE.
  always_comb begin
    done_next = ((state == DONE) || (state == FAIL)) && start;
`ifdef RC4_VALID_CHECK_EN
    valid_next = (state == DONE) && start;
`else
    valid_next = done_next;
`endif
  end

  // Datapath: indices, swap operands and registered memory addresses/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i         <= '0;
      j         <= '0;
      k         <= '0;
      f         <= '0;
      si        <= '0;
      sj        <= '0;
      address_S <= '0;
      data_S    <= '0;
      address_C <= '0;
      address_D <= '0;
      data_D    <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      done  <= done_next;
      valid <= valid_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            i <= 8'd1;
            j <= 8'd0;
            k <= '0;
          end
        end
        RD_I:   address_S <= i;
        CALC_J: begin
          si <= q_S;
          j  <= j + q_S;
        end
        RD_J:   address_S <= j;
        SET_I: begin
          sj        <= q_S;
          address_S <= i;
          data_S    <= q_S;
        end
        SET_J: begin
          address_S <= j;
          data_S    <= si;
        end
        WR_J:   f <= si + sj;
        RD_F: begin
          address_S <= f;
          address_C <= k;
        end
        CALC_D: begin
          data_D    <= plain;
          address_D <= k;
        end
        NEXT: begin
          if (k != K_LAST) begin
            k <= k + MSG_AW'(1);
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
